// File: rtl/gfx_clip_zcmp.sv
// Clip / z-cull stage: source mux, target/clip-rect discard, configurable depth test
// against a wide z-buffer bus with optional Z write-back, then hand-off to the fragment stage.
module gfx_clip_zcmp #(
    parameter int PW       = 16,
    parameter int ZW       = 16,
    parameter int SW       = 256,
    parameter int ADDR_LAT = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clipping_enable_i,
    input  logic            zbuffer_enable_i,
    input  logic [2:0]      zfunc_i,
    input  logic            zwrite_enable_i,
    input  logic [31:0]     zbuffer_base_i,
    input  logic [PW-1:0]   target_size_x_i,
    input  logic [PW-1:0]   target_x0_i,
    input  logic [PW-1:0]   target_y0_i,
    input  logic [PW-1:0]   target_x1_i,
    input  logic [PW-1:0]   target_y1_i,
    input  logic [PW-1:0]   clip_x0_i,
    input  logic [PW-1:0]   clip_y0_i,
    input  logic [PW-1:0]   clip_x1_i,
    input  logic [PW-1:0]   clip_y1_i,
    input  logic [PW-1:0]   raster_x_i,
    input  logic [PW-1:0]   raster_y_i,
    input  logic [PW-1:0]   raster_u_i,
    input  logic [PW-1:0]   raster_v_i,
    input  logic [31:0]     flat_color_i,
    input  logic            raster_write_i,
    input  logic [PW-1:0]   cuvz_x_i,
    input  logic [PW-1:0]   cuvz_y_i,
    input  logic [PW-1:0]   cuvz_u_i,
    input  logic [PW-1:0]   cuvz_v_i,
    input  logic [ZW-1:0]   cuvz_z_i,
    input  logic [7:0]      cuvz_a_i,
    input  logic [31:0]     cuvz_color_i,
    input  logic            cuvz_write_i,
    output logic            ack_o,
    output logic            z_rd_request_o,
    input  logic            z_rd_ack_i,
    input  logic [SW-1:0]   z_rd_data_i,
    output logic [31:0]     z_addr_o,
    output logic            z_wr_request_o,
    input  logic            z_wr_ack_i,
    output logic [SW-1:0]   z_wr_data_o,
    output logic [SW/8-1:0] z_wr_sel_o,
    input  logic            wbm_busy_i,
    output logic [PW-1:0]   pixel_x_o,
    output logic [PW-1:0]   pixel_y_o,
    output logic [PW-1:0]   u_o,
    output logic [PW-1:0]   v_o,
    output logic [ZW-1:0]   pixel_z_o,
    output logic [7:0]      a_o,
    output logic [31:0]     color_o,
    output logic            write_o,
    input  logic            ack_i
);

    localparam int ZB    = ZW / 8;
    localparam int BB    = SW / 8;
    localparam int ZLB   = $clog2(ZB);
    localparam int LANES = SW / ZW;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [2:0] LAST = 3'(ADDR_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ZREAD, S_ZWRITE, S_WRPIX} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            raster_q, raster_d;
    logic [PW-1:0]   x_q, x_d, y_q, y_d, u_q, u_d, v_q, v_d;
    logic [ZW-1:0]   z_q, z_d;
    logic [7:0]      a_q, a_d;
    logic [31:0]     color_q, color_d;
    logic            ack_q, ack_d, write_q, write_d;
    logic            rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic [31:0]     addr_q, addr_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [SW-1:0]   wr_data_q, wr_data_d;
    logic [BB-1:0]   wr_sel_q, wr_sel_d;

    logic [PW-1:0]   src_x, src_y;
    logic            in_tgt, in_clip, discard;
    logic [31:0]     offset, addr_calc;
    logic [LW-1:0]   lane_calc;
    logic [ZW-1:0]   stored_z;
    logic            zpass;

    assign src_x   = raster_write_i ? raster_x_i : cuvz_x_i;
    assign src_y   = raster_write_i ? raster_y_i : cuvz_y_i;
    assign in_tgt  = (src_x >= target_x0_i) && (src_x < target_x1_i) &&
                     (src_y >= target_y0_i) && (src_y < target_y1_i);
    assign in_clip = (src_x >= clip_x0_i) && (src_x < clip_x1_i) &&
                     (src_y >= clip_y0_i) && (src_y < clip_y1_i);
    assign discard = !in_tgt || (clipping_enable_i && !in_clip);

    // Address is recomputed every ADDR cycle from the latched pixel; the last value wins.
    assign offset    = (32'(y_q) * 32'(target_size_x_i) + 32'(x_q)) * 32'(ZB);
    assign addr_calc = (zbuffer_base_i + offset) & ~32'(BB - 1);
    assign lane_calc = LW'((offset & 32'(BB - 1)) >> ZLB);
    assign stored_z  = z_rd_data_i[int'(lane_q) * ZW +: ZW];

    always_comb begin
        zpass = 1'b0;
        case (zfunc_i)
            3'd1:    zpass = $signed(z_q) <  $signed(stored_z);
            3'd2:    zpass = $signed(z_q) <= $signed(stored_z);
            3'd3:    zpass = $signed(z_q) == $signed(stored_z);
            3'd4:    zpass = $signed(z_q) >  $signed(stored_z);
            3'd5:    zpass = $signed(z_q) >= $signed(stored_z);
            3'd6:    zpass = $signed(z_q) != $signed(stored_z);
            3'd7:    zpass = 1'b1;
            default: zpass = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        raster_d  = raster_q;
        x_d       = x_q;
        y_d       = y_q;
        u_d       = u_q;
        v_d       = v_q;
        z_d       = z_q;
        a_d       = a_q;
        color_d   = color_q;
        ack_d     = 1'b0;
        write_d   = 1'b0;
        rd_req_d  = rd_req_q;
        wr_req_d  = wr_req_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        wr_data_d = wr_data_q;
        wr_sel_d  = wr_sel_q;
        case (state_q)
            S_IDLE: begin
                if (raster_write_i || cuvz_write_i) begin
                    raster_d = raster_write_i;
                    x_d      = src_x;
                    y_d      = src_y;
                    u_d      = raster_write_i ? raster_u_i : cuvz_u_i;
                    v_d      = raster_write_i ? raster_v_i : cuvz_v_i;
                    z_d      = raster_write_i ? '0 : cuvz_z_i;
                    a_d      = raster_write_i ? 8'hFF : cuvz_a_i;
                    color_d  = raster_write_i ? flat_color_i : cuvz_color_i;
                    if (discard) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                    end
                end
            end
            S_ADDR: begin
                addr_d = addr_calc;
                lane_d = lane_calc;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == LAST) begin
                    if (raster_q || !zbuffer_enable_i) begin
                        state_d = S_WRPIX;
                        write_d = 1'b1;
                    end else if (zfunc_i == 3'd0) begin
                        state_d = S_IDLE;
                        ack_d   = 1'b1;
                    end else if (zfunc_i == 3'd7 && !zwrite_enable_i) begin
                        state_d = S_WRPIX;
                        write_d = 1'b1;
                    end else begin
                        state_d = S_ZREAD;
                    end
                end
            end
            S_ZREAD: begin
                if (rd_req_q) begin
                    if (z_rd_ack_i) begin
                        rd_req_d = 1'b0;
                        if (!zpass) begin
                            state_d = S_IDLE;
                            ack_d   = 1'b1;
                        end else if (zwrite_enable_i) begin
                            state_d   = S_ZWRITE;
                            wr_data_d = {LANES{z_q}};
                            wr_sel_d  = BB'((1 << ZB) - 1) << (int'(lane_q) * ZB);
                        end else begin
                            state_d = S_WRPIX;
                            write_d = 1'b1;
                        end
                    end
                end else if (!wbm_busy_i) begin
                    rd_req_d = 1'b1;
                end
            end
            S_ZWRITE: begin
                if (wr_req_q) begin
                    if (z_wr_ack_i) begin
                        wr_req_d = 1'b0;
                        wr_sel_d = '0;
                        state_d  = S_WRPIX;
                        write_d  = 1'b1;
                    end
                end else if (!wbm_busy_i) begin
                    wr_req_d = 1'b1;
                end
            end
            S_WRPIX: begin
                if (ack_i) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            raster_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            u_q       <= '0;
            v_q       <= '0;
            z_q       <= '0;
            a_q       <= '0;
            color_q   <= '0;
            ack_q     <= 1'b0;
            write_q   <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            addr_q    <= '0;
            lane_q    <= '0;
            wr_data_q <= '0;
            wr_sel_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            raster_q  <= raster_d;
            x_q       <= x_d;
            y_q       <= y_d;
            u_q       <= u_d;
            v_q       <= v_d;
            z_q       <= z_d;
            a_q       <= a_d;
            color_q   <= color_d;
            ack_q     <= ack_d;
            write_q   <= write_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            addr_q    <= addr_d;
            lane_q    <= lane_d;
            wr_data_q <= wr_data_d;
            wr_sel_q  <= wr_sel_d;
        end
    end

    assign ack_o          = ack_q;
    assign write_o        = write_q;
    assign z_rd_request_o = rd_req_q;
    assign z_wr_request_o = wr_req_q;
    assign z_addr_o       = addr_q;
    assign z_wr_data_o    = wr_data_q;
    assign z_wr_sel_o     = wr_sel_q;
    assign pixel_x_o      = x_q;
    assign pixel_y_o      = y_q;
    assign u_o            = u_q;
    assign v_o            = v_q;
    assign pixel_z_o      = z_q;
    assign a_o            = a_q;
    assign color_o        = color_q;

endmodule

// File: doc/gfx_clip_zcmp.md
Name: gfx_clip_zcmp

Overview:
- Parametrised successor to the 256-bit clip/z-cull stage.
- Sits between raster/cuvz and the fragment stage.
- Muxes the pixel source, applies target-rect and optional clip-rect discard, then runs a depth test against the z-buffer.
- The depth compare function is selectable, the z-buffer read bus is any width, address latency is configurable, and the passing Z can optionally be written back through the wishbone writer.

Parameters:
PW, 16, point/coordinate width
ZW, 16, depth word width (16 or 32)
SW, 256, z-buffer bus width in bits (64/128/256)
ADDR_LAT, 2, address-calc pipeline stages (1..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; synchronous, active-low
clipping_enable_i  in  1  apply clip rect
zbuffer_enable_i  in  1  enable depth test
zfunc_i  in  3  0 never,1 less,2 lequal,3 equal,4 greater,5 gequal,6 notequal,7 always
zwrite_enable_i  in  1  write passing Z back
zbuffer_base_i  in  32  z-buffer byte base
target_size_x_i  in  PW  z-buffer pitch in pixels
target_x0_i,target_y0_i,target_x1_i,target_y1_i  in  PW each  target rect, [x0,x1)×[y0,y1)
clip_x0_i,clip_y0_i,clip_x1_i,clip_y1_i  in  PW each  clip rect, half-open
raster_x_i,raster_y_i,raster_u_i,raster_v_i  in  PW each  raster pixel
flat_color_i  in  32  raster color
raster_write_i  in  1  raster strobe; priority over cuvz
cuvz_x_i,cuvz_y_i,cuvz_u_i,cuvz_v_i  in  PW each  cuvz pixel
cuvz_z_i  in  ZW  signed depth
cuvz_a_i  in  8  alpha
cuvz_color_i  in  32  color
cuvz_write_i  in  1  cuvz strobe
ack_o  out  1  one-cycle done pulse to upstream
z_rd_request_o  out  1  read request
z_rd_ack_i  in  1  read data valid
z_rd_data_i  in  SW  read word
z_addr_o  out  32  SW/8-aligned byte address (shared by read and write)
z_wr_request_o  out  1  write request
z_wr_ack_i  in  1  write done
z_wr_data_o  out  SW  Z replicated across all lanes
z_wr_sel_o  out  SW/8  byte enables of target lane
wbm_busy_i  in  1  master busy
pixel_x_o,pixel_y_o,u_o,v_o  out  PW each  to fragment
pixel_z_o  out  ZW  to fragment
a_o  out  8  alpha
color_o  out  32  color
write_o  out  1  one-cycle fragment strobe
ack_i  in  1  fragment done

Behaviour:
- Reset (rst_i==0 at clk edge): state IDLE; all outputs 0; z_wr_sel_o 0.
- IDLE, on strobe:
  - Latch the selected source into output regs. Raster: a=8'hFF, z=0.
  - Discard = outside target | (clipping_enable_i & outside clip). Comparisons unsigned, half-open.
  - Discarded: ack_o pulses next cycle, stay IDLE.
  - Otherwise go to ADDR.
- Strobes while not IDLE are ignored; upstream must wait for ack_o.
- ADDR:
  - Byte offset = (y*pitch + x)*(ZW/8), 32-bit wrap.
  - z_addr_o = base + offset with low log2(SW/8) bits cleared.
  - lane = offset[log2(SW/8)-1:0]/(ZW/8).
  - Hold ADDR_LAT cycles, then:
    - raster source or !zbuffer_enable_i → WRPIX, with write_o=1 on entry;
    - zfunc never → ack_o pulse, back to IDLE;
    - zfunc always with !zwrite_enable_i → WRPIX (no read);
    - else → ZREAD.
- ZREAD:
  - z_rd_request_o asserted when !wbm_busy_i; held until z_rd_ack_i.
  - On ack: drop the request; extract lane Z (signed); pass = cuvz_z OP stored_z.
  - Fail → ack_o pulse, IDLE.
  - Pass with zwrite_enable_i → ZWRITE.
  - Pass without it → WRPIX.
- ZWRITE:
  - z_wr_request_o asserted when !wbm_busy_i; data = cuvz_z replicated; sel = ZW/8 ones at the lane.
  - On z_wr_ack_i: drop request → WRPIX.
- WRPIX: write_o high exactly one cycle; wait ack_i; then ack_o pulse and IDLE.
- ack_o is never high for more than one cycle.
- ack_i arriving in the same cycle write_o rises is accepted.
- Reset mid-transaction: all requests drop at that edge, no ack_o.

Test Plan:
- Raster (10,10), target [0,640)×[0,480), clip disabled → write_o after ADDR_LAT+1 cycles, pixel_z_o=0, a_o=FF, ack_o after ack_i.
- Cuvz x=640 → ack_o next cycle, no request, no write_o.
- Clip [0,100), x=100, clipping on → discard; clipping off → write_o.
- ZW=16, SW=256, pitch=640, base 0, (17,1): z_addr_o=0x520, lane 1. Stored 0x0040, z 0x0030, less → write_o; greater → ack_o, no write_o.
- Pass with zwrite_enable_i, lane 1: z_wr_sel_o=32'h0000000C and data replicated; z_wr_ack_i delayed 5 cycles → write_o only afterwards.
- wbm_busy_i high 3 cycles in ZREAD → no request until it drops. rst_i low mid-ZWRITE → all outputs 0, IDLE.
